// File: rtl/uart_tx_packetizer.sv
// uart_tx_packetizer
//   Frames a packet into the UART TX FIFO one byte per cycle:
//   SOF, LEN, payload[0..N-1], CHK where CHK = LEN ^ payload[0] ^ ... ^ payload[N-1].
//   The FIFO full flag is honoured, so no byte is ever dropped.
//
// Ports
//   i_clk        system clock (UART domain)
//   i_rst        synchronous reset, active high
//   i_en         gates acceptance of a new packet command only
//   i_cmd_valid  packet request valid; i_cmd_len = payload byte count
//   o_cmd_ready  high only in IDLE while i_en is high
//   i_s_valid    payload byte valid; i_s_data = payload byte
//   o_s_ready    payload byte consumed when i_s_valid & o_s_ready
//   i_tx_full    TX FIFO full flag
//   o_wr         TX FIFO write strobe; o_wdata = byte written
//   o_busy       packet in progress
//   o_pkt_done   one-cycle pulse in the cycle after CHK is written
module uart_tx_packetizer #(
  parameter logic [7:0] SOF = 8'hA5,
  parameter int         LW  = 8       // LEN goes out as a single byte
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic [LW-1:0] i_cmd_len,
  input  logic          i_s_valid,
  output logic          o_s_ready,
  input  logic [7:0]    i_s_data,
  input  logic          i_tx_full,
  output logic          o_wr,
  output logic [7:0]    o_wdata,
  output logic          o_busy,
  output logic          o_pkt_done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_cnt;     // payload bytes still to be written
  logic [7:0]    r_chk;
  logic          r_pkt_done;

  assign o_pkt_done = r_pkt_done;

  // Next state and output decode
  always_comb begin
    w_state_nxt = r_state;
    o_wr        = 1'b0;
    o_wdata     = 8'h00;
    o_s_ready   = 1'b0;
    o_cmd_ready = 1'b0;
    o_busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        o_cmd_ready = i_en;
        if (i_cmd_valid && i_en) w_state_nxt = ST_SOF;
      end
      ST_SOF: begin
        o_wr    = ~i_tx_full;
        o_wdata = SOF;
        if (o_wr) w_state_nxt = ST_LEN;
      end
      ST_LEN: begin
        o_wr    = ~i_tx_full;
        o_wdata = r_len;
        if (o_wr) w_state_nxt = (r_len != '0) ? ST_DATA : ST_CHK;
      end
      ST_DATA: begin
        // A byte is only consumed when it can be written, so a full FIFO
        // never loses or duplicates payload.
        o_s_ready = ~i_tx_full;
        o_wr      = i_s_valid & ~i_tx_full;
        o_wdata   = i_s_data;
        // Compare the pre-decrement count so that 255 does not wrap early.
        if (o_wr && r_cnt == LW'(1)) w_state_nxt = ST_CHK;
      end
      ST_CHK: begin
        o_wr    = ~i_tx_full;
        o_wdata = r_chk;
        if (o_wr) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_cnt      <= '0;
      r_chk      <= 8'h00;
      r_pkt_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pkt_done <= (r_state == ST_CHK) && o_wr;
      if (r_state == ST_IDLE && i_cmd_valid && i_en) begin
        r_len <= i_cmd_len;
        r_cnt <= i_cmd_len;
        r_chk <= i_cmd_len;   // LEN is part of the checksum
      end
      if (r_state == ST_DATA && o_wr) begin
        r_chk <= r_chk ^ i_s_data;
        r_cnt <= r_cnt - LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_packetizer.sv
module tb_uart_tx_packetizer;

  logic       clk = 1'b0;
  logic       rst, en, cmd_valid, s_valid, tx_full;
  logic [7:0] cmd_len, s_data;
  logic       cmd_ready, s_ready, wr, busy, pkt_done;
  logic [7:0] wdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_packetizer dut (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_len(cmd_len),
    .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data),
    .i_tx_full(tx_full), .o_wr(wr), .o_wdata(wdata),
    .o_busy(busy), .o_pkt_done(pkt_done)
  );

  // One row = inputs held for one cycle + outputs expected in that cycle.
  typedef struct {
    bit       rst, en, cv;
    bit [7:0] len;
    bit       sv;
    bit [7:0] sd;
    bit       full;
    bit       ck;
    bit       wr;
    bit [7:0] wd;
    bit       sr, cr, busy, done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(bit r, bit e, bit c, bit [7:0] l, bit v, bit [7:0] d,
                             bit f, bit k, bit w, bit [7:0] wdx, bit s, bit cr,
                             bit b, bit dn);
    vec_t t;
    t.rst = r; t.en = e; t.cv = c; t.len = l; t.sv = v; t.sd = d; t.full = f;
    t.ck = k; t.wr = w; t.wd = wdx; t.sr = s; t.cr = cr; t.busy = b; t.done = dn;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    //          rst en cv len  sv sd    full ck  wr wd    sr cr bsy dn
    // reset state
    tbl.push_back(V(1,1,0,8'h00,0,8'h00,0, 1, 0,8'h00,0,1,0,0));
    // basic packet, len 3 payload 01 02 03 -> A5 03 01 02 03 03
    tbl.push_back(V(0,1,1,8'h03,0,8'h00,0, 1, 0,8'h00,0,1,0,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 1,8'hA5,0,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 1,8'h03,0,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,1,8'h01,0, 1, 1,8'h01,1,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,1,8'h02,0, 1, 1,8'h02,1,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,1,8'h03,0, 1, 1,8'h03,1,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 1,8'h03,0,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 0,8'h00,0,1,0,1));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 0,8'h00,0,1,0,0));
    // empty payload -> A5 00 00
    tbl.push_back(V(0,1,1,8'h00,0,8'h00,0, 1, 0,8'h00,0,1,0,0));
    tbl.push_back(V(0,1,0,8'h00,1,8'h77,0, 1, 1,8'hA5,0,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,1,8'h77,0, 1, 1,8'h00,0,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,1,8'h77,0, 1, 1,8'h00,0,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 0,8'h00,0,1,0,1));
    // backpressure: full in SOF, 4 cycles in DATA on 0x55, and in CHK
    tbl.push_back(V(0,1,1,8'h01,0,8'h00,0, 1, 0,8'h00,0,1,0,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,1, 1, 0,8'hA5,0,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 1,8'hA5,0,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 1,8'h01,0,0,1,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(V(0,1,0,8'h00,1,8'h55,1, 1, 0,8'h55,0,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,1,8'h55,0, 1, 1,8'h55,1,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,1, 1, 0,8'h54,0,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 1,8'h54,0,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 0,8'h00,0,1,0,1));
    // source stall: AA, gap, gap, BB -> A5 02 AA BB 13
    tbl.push_back(V(0,1,1,8'h02,0,8'h00,0, 1, 0,8'h00,0,1,0,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 1,8'hA5,0,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 1,8'h02,0,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,1,8'hAA,0, 1, 1,8'hAA,1,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 0,8'h00,1,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 0,8'h00,1,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,1,8'hBB,0, 1, 1,8'hBB,1,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 1,8'h13,0,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 0,8'h00,0,1,0,1));
    // busy rejection + en dropping mid-packet; len 1 payload 07 -> CHK 06
    tbl.push_back(V(0,1,1,8'h01,0,8'h00,0, 1, 0,8'h00,0,1,0,0));
    tbl.push_back(V(0,0,1,8'h02,0,8'h00,0, 1, 1,8'hA5,0,0,1,0));
    tbl.push_back(V(0,0,1,8'h02,0,8'h00,0, 1, 1,8'h01,0,0,1,0));
    tbl.push_back(V(0,0,1,8'h02,1,8'h07,0, 1, 1,8'h07,1,0,1,0));
    tbl.push_back(V(0,0,1,8'h02,0,8'h00,0, 1, 1,8'h06,0,0,1,0));
    tbl.push_back(V(0,0,1,8'h02,0,8'h00,0, 1, 0,8'h00,0,0,0,1)); // en=0 blocks start
    tbl.push_back(V(0,1,1,8'h02,0,8'h00,0, 1, 0,8'h00,0,1,0,0)); // packet 2 accepted
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 1,8'hA5,0,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 1,8'h02,0,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,1,8'h10,0, 1, 1,8'h10,1,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,1,8'h20,0, 1, 1,8'h20,1,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 1,8'h32,0,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 0,8'h00,0,1,0,1));
    // reset mid-packet (len 10), then len 1 payload FF -> A5 01 FF FE
    tbl.push_back(V(0,1,1,8'h0A,0,8'h00,0, 1, 0,8'h00,0,1,0,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 1,8'hA5,0,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 1,8'h0A,0,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,1,8'h11,0, 1, 1,8'h11,1,0,1,0));
    tbl.push_back(V(1,1,0,8'h00,1,8'h22,0, 0, 0,8'h00,0,0,0,0));
    tbl.push_back(V(0,1,1,8'h01,0,8'h00,0, 1, 0,8'h00,0,1,0,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 1,8'hA5,0,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 1,8'h01,0,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,1,8'hFF,0, 1, 1,8'hFF,1,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 1,8'hFE,0,0,1,0));
    tbl.push_back(V(0,1,0,8'h00,0,8'h00,0, 1, 0,8'h00,0,1,0,1));

    rst = 1; en = 0; cmd_valid = 0; cmd_len = 0; s_valid = 0; s_data = 0; tx_full = 0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; en = tbl[i].en; cmd_valid = tbl[i].cv; cmd_len = tbl[i].len;
      s_valid = tbl[i].sv; s_data = tbl[i].sd; tx_full = tbl[i].full;
      #1;
      if (tbl[i].ck) begin
        checks++;
        if ({wr, wdata, s_ready, cmd_ready, busy, pkt_done} !==
            {tbl[i].wr, tbl[i].wd, tbl[i].sr, tbl[i].cr, tbl[i].busy, tbl[i].done}) begin
          errors++;
          $display("FAIL row%0d: got wr=%b wd=%h sr=%b cr=%b busy=%b done=%b expected wr=%b wd=%h sr=%b cr=%b busy=%b done=%b",
                   i, wr, wdata, s_ready, cmd_ready, busy, pkt_done,
                   tbl[i].wr, tbl[i].wd, tbl[i].sr, tbl[i].cr, tbl[i].busy, tbl[i].done);
        end
      end
    end

    // 255-byte payload with intermittent FIFO full: 258 bytes, no early wrap
    begin
      logic [7:0] bytes[$];
      logic [7:0] exp_chk;
      int p, bad;
      bit seen_done;
      p = 0; bad = 0; seen_done = 0;
      @(negedge clk);
      en = 1; cmd_valid = 1; cmd_len = 8'hFF; s_valid = 0; tx_full = 0;
      @(negedge clk);
      cmd_valid = 0; cmd_len = 0; s_valid = 1;
      for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
        if (cyc != 0) @(negedge clk);
        tx_full = (cyc % 7 == 3);
        s_data  = p[7:0];
        #1;
        if (pkt_done) seen_done = 1;
        else begin
          if (wr) bytes.push_back(wdata);
          if (s_valid && s_ready) p++;
        end
      end
      exp_chk = 8'hFF;
      for (int i = 0; i < 255; i++) exp_chk ^= 8'(i);
      check("len255_done", 32'(seen_done), 32'd1);
      check("len255_count", bytes.size(), 258);
      if (bytes.size() == 258) begin
        check("len255_sof", 32'(bytes[0]), 32'hA5);
        check("len255_len", 32'(bytes[1]), 32'hFF);
        for (int i = 0; i < 255; i++) if (bytes[i+2] !== 8'(i)) bad++;
        check("len255_payload_errs", bad, 0);
        check("len255_chk", 32'(bytes[257]), 32'(exp_chk));
      end
      s_valid = 0; tx_full = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
